// File: rtl/tetris_pkg.sv
// Shared types and dimensions for the tetromino datapath: sequencer state,
// checker request modes, coordinate widths and board size.
package tetris_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_CHECK = 3'd4,
        S_LOCK  = 3'd5,
        S_OVER  = 3'd6
    } seq_state_t;

    typedef enum logic [1:0] {
        CHK_GRAV  = 2'd0,
        CHK_LEFT  = 2'd1,
        CHK_RIGHT = 2'd2
    } chk_mode_t;

    localparam int X_W   = 5;
    localparam int Y_W   = 6;
    localparam int BLK_W = 3;
    localparam int ROT_W = 2;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 24;

endpackage

// File: rtl/gravity_timer.sv
// Free-running gravity divider: counts enabled cycles and pulses wrap_o on the
// last count. PIECE_SEQ_SOFT_DROP_EN adds key_down_i, which shortens the period to GRAVITY_DIV/8.
module gravity_timer
    import tetris_pkg::*;
#(
    parameter int GRAVITY_DIV = 25_000_000
)
(
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
`ifdef PIECE_SEQ_SOFT_DROP_EN
    input  logic key_down_i,
`endif
    output logic wrap_o
);

    localparam int CNT_W = $clog2(GRAVITY_DIV);
    localparam logic [CNT_W-1:0] LAST_NORM = CNT_W'(GRAVITY_DIV - 1);
`ifdef PIECE_SEQ_SOFT_DROP_EN
    localparam logic [CNT_W-1:0] LAST_SOFT = CNT_W'(GRAVITY_DIV / 8 - 1);
`endif

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last;

    // A >= compare lets a switch to the short period wrap on the next cycle
    // even when the count is already past the new limit.
    always_comb begin
`ifdef PIECE_SEQ_SOFT_DROP_EN
        last = key_down_i ? LAST_SOFT : LAST_NORM;
`else
        last = LAST_NORM;
`endif
        wrap_o = en_i && (cnt_q >= last);
        cnt_d  = cnt_q;
        if (clr_i || wrap_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piece_sequencer.sv
// Active-piece sequencer: spawn, gravity, left/right moves and lock, driving the
// collision checker one request at a time. PIECE_SEQ_SOFT_DROP_EN adds a key_down soft-drop input.
module piece_sequencer
    import tetris_pkg::*;
#(
    parameter int GRAVITY_DIV = 25_000_000,
    parameter int SPAWN_X     = 4,
    parameter int SPAWN_Y     = 0
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             key_left,
    input  logic             key_right,
`ifdef PIECE_SEQ_SOFT_DROP_EN
    input  logic             key_down,
`endif
    input  logic [BLK_W-1:0] next_block,
    output logic             chk_en,
    output logic             chk_left,
    output logic             chk_right,
    input  logic [X_W-1:0]   chk_x_in,
    input  logic [Y_W-1:0]   chk_y_in,
    input  logic             chk_collision,
    input  logic             chk_done,
    output logic [X_W-1:0]   piece_x,
    output logic [Y_W-1:0]   piece_y,
    output logic [BLK_W-1:0] piece_block,
    output logic [ROT_W-1:0] piece_rot,
    output logic             lock_req,
    input  logic             lock_ack,
    output logic             game_over,
    output logic [2:0]       dbg_state
);

    seq_state_t       state_q, state_d;
    chk_mode_t        mode_q, mode_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic [ROT_W-1:0] rot_q, rot_d;
    logic             grav_pend_q, grav_pend_d;
    logic             lft_pend_q, lft_pend_d;
    logic             rgt_pend_q, rgt_pend_d;
    logic             active, grav_wrap;

    assign active = (state_q == S_WAIT) || (state_q == S_ISSUE) || (state_q == S_CHECK);

    gravity_timer #(.GRAVITY_DIV(GRAVITY_DIV)) u_gravity_timer (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (state_q == S_SPAWN),
        .en_i       (active),
`ifdef PIECE_SEQ_SOFT_DROP_EN
        .key_down_i (key_down),
`endif
        .wrap_o     (grav_wrap)
    );

    // Checker handshake: chk_en is held with all checker inputs stable until
    // chk_done is sampled high; that same edge commits the result and ends the request.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        x_d         = x_q;
        y_d         = y_q;
        blk_d       = blk_q;
        rot_d       = rot_q;
        grav_pend_d = grav_pend_q;
        lft_pend_d  = lft_pend_q;
        rgt_pend_d  = rgt_pend_q;

        unique case (state_q)
            S_IDLE, S_OVER: if (start) state_d = S_SPAWN;
            S_SPAWN: begin
                blk_d       = next_block;
                x_d         = X_W'(SPAWN_X);
                y_d         = Y_W'(SPAWN_Y);
                rot_d       = '0;
                lft_pend_d  = 1'b0;
                rgt_pend_d  = 1'b0;
                grav_pend_d = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (grav_pend_q) begin
                    grav_pend_d = 1'b0;
                    mode_d      = CHK_GRAV;
                    state_d     = S_ISSUE;
                end else if (lft_pend_q) begin
                    lft_pend_d = 1'b0;
                    mode_d     = CHK_LEFT;
                    state_d    = S_ISSUE;
                end else if (rgt_pend_q) begin
                    rgt_pend_d = 1'b0;
                    mode_d     = CHK_RIGHT;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_CHECK;
            S_CHECK: begin
                if (chk_done) begin
                    if (mode_q != CHK_GRAV) begin
                        x_d     = chk_x_in;
                        state_d = S_WAIT;
                    end else if (!chk_collision) begin
                        y_d     = chk_y_in;
                        state_d = S_WAIT;
                    end else if (y_q == Y_W'(SPAWN_Y)) begin
                        state_d = S_OVER;
                    end else begin
                        state_d = S_LOCK;
                    end
                end
            end
            S_LOCK: if (lock_ack) state_d = S_SPAWN;
            default: state_d = S_IDLE;
        endcase

        // New requests are applied after selection so a same-cycle event re-arms the bit.
        if (grav_wrap) grav_pend_d = 1'b1;
        if (active && key_left && !key_right) lft_pend_d = 1'b1;
        if (active && key_right && !key_left) rgt_pend_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mode_q      <= CHK_GRAV;
            x_q         <= '0;
            y_q         <= '0;
            blk_q       <= '0;
            rot_q       <= '0;
            grav_pend_q <= 1'b0;
            lft_pend_q  <= 1'b0;
            rgt_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            x_q         <= x_d;
            y_q         <= y_d;
            blk_q       <= blk_d;
            rot_q       <= rot_d;
            grav_pend_q <= grav_pend_d;
            lft_pend_q  <= lft_pend_d;
            rgt_pend_q  <= rgt_pend_d;
        end
    end

    assign chk_en      = (state_q == S_CHECK);
    assign chk_left    = (state_q == S_ISSUE || state_q == S_CHECK) && (mode_q == CHK_LEFT);
    assign chk_right   = (state_q == S_ISSUE || state_q == S_CHECK) && (mode_q == CHK_RIGHT);
    assign lock_req    = (state_q == S_LOCK);
    assign game_over   = (state_q == S_OVER);
    assign piece_x     = x_q;
    assign piece_y     = y_q;
    assign piece_block = blk_q;
    assign piece_rot   = rot_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_piece_sequencer.sv
// Self-checking bench for piece_sequencer with a behavioural collision checker
// that completes on its 4th enabled cycle; commits are scored against an expected queue.
module tb_piece_sequencer;
    import tetris_pkg::*;

    localparam int GDIV = 16;
    localparam int SB_W = 13;

    logic clk = 1'b0;
    logic reset, start, key_left, key_right, lock_ack, coll_force;
`ifdef PIECE_SEQ_SOFT_DROP_EN
    logic key_down = 1'b0;
`endif
    logic [2:0] next_block;
    logic chk_en, chk_left, chk_right, chk_collision, chk_done;
    logic [4:0] chk_x_in, piece_x;
    logic [5:0] chk_y_in, piece_y;
    logic [2:0] piece_block, dbg_state;
    logic [1:0] piece_rot;
    logic lock_req, game_over;

    int n_tests = 0;
    int n_fail  = 0;
    logic [SB_W-1:0] exp_q[$];

    piece_sequencer #(.GRAVITY_DIV(GDIV), .SPAWN_X(4), .SPAWN_Y(0)) dut (
        .clk(clk), .reset(reset), .start(start),
        .key_left(key_left), .key_right(key_right),
`ifdef PIECE_SEQ_SOFT_DROP_EN
        .key_down(key_down),
`endif
        .next_block(next_block),
        .chk_en(chk_en), .chk_left(chk_left), .chk_right(chk_right),
        .chk_x_in(chk_x_in), .chk_y_in(chk_y_in),
        .chk_collision(chk_collision), .chk_done(chk_done),
        .piece_x(piece_x), .piece_y(piece_y),
        .piece_block(piece_block), .piece_rot(piece_rot),
        .lock_req(lock_req), .lock_ack(lock_ack),
        .game_over(game_over), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- checker model
    int en_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) en_cnt <= 0;
        else if (chk_en && !chk_done) en_cnt <= en_cnt + 1;
        else en_cnt <= 0;
    end
    assign chk_done      = chk_en && (en_cnt == 3);
    assign chk_x_in      = chk_left ? piece_x - 5'd1 : (chk_right ? piece_x + 5'd1 : piece_x);
    assign chk_y_in      = piece_y + 6'd1;
    assign chk_collision = coll_force;

    // ---------------- checking
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard
    logic       cmp_pend = 1'b0;
    logic [1:0] cmp_mode;
    always @(negedge clk) begin
        logic [SB_W-1:0] e;
        if (reset) begin
            cmp_pend = 1'b0;
        end else begin
            if (cmp_pend) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_unexpected_commit", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("sb_mode", cmp_mode, e[12:11]);
                    check_eq("sb_x", piece_x, e[10:6]);
                    check_eq("sb_y", piece_y, e[5:0]);
                end
                cmp_pend = 1'b0;
            end
            if (chk_en && chk_done) begin
                cmp_pend = 1'b1;
                cmp_mode = chk_right ? 2'd2 : (chk_left ? 2'd1 : 2'd0);
            end
        end
    end

    // ---------------- driver tasks
    task automatic push_exp(input logic [1:0] m, input logic [4:0] x, input logic [5:0] y);
        exp_q.push_back({m, x, y});
    endtask

    // Returns on the negedge where the committed result is visible.
    task automatic wait_commit(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (chk_en && chk_done) seen = 1'b1;
        end
        check_eq({tag, "_timeout"}, seen, 1);
        if (seen) @(negedge clk);
    endtask

    // ---------------- stimulus
    initial begin
        int ey;
        int lock_cnt;
        bit en_seen;

        reset = 1'b1; start = 1'b0; key_left = 1'b0; key_right = 1'b0;
        lock_ack = 1'b0; next_block = 3'd0; coll_force = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst_state", dbg_state, S_IDLE);
        check_eq("rst_outs", {chk_en, chk_left, chk_right, lock_req, game_over}, 0);
        check_eq("rst_piece", {piece_x, piece_y, piece_block, piece_rot}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_hold", dbg_state, S_IDLE);

        // spawn and first gravity drop
        next_block = 3'd3; start = 1'b1;
        push_exp(CHK_GRAV, 5'd4, 6'd1);
        @(negedge clk); start = 1'b0;
        check_eq("spawn_state", dbg_state, S_SPAWN);
        @(negedge clk);
        check_eq("spawn_xy", {piece_x, piece_y}, {5'd4, 6'd0});
        check_eq("spawn_rot", piece_rot, 0);
        check_eq("spawn_blk", piece_block, 3);
        check_eq("spawn_wait", dbg_state, S_WAIT);
        next_block = 3'd6;
        @(negedge clk);
        check_eq("issue_state", dbg_state, S_ISSUE);
        check_eq("issue_en", chk_en, 0);
        check_eq("grav_mode", {chk_left, chk_right}, 0);
        @(negedge clk);
        check_eq("check_en", chk_en, 1);
        repeat (3) @(negedge clk);
        check_eq("y_before_commit", piece_y, 0);
        @(negedge clk);
        check_eq("grav_latency_y", piece_y, 1);

        // left move: x-1, y unchanged
        key_left = 1'b1;
        push_exp(CHK_LEFT, 5'd3, 6'd1);
        @(negedge clk); key_left = 1'b0;
        wait_commit("left");
        check_eq("left_y_same", piece_y, 1);
        push_exp(CHK_GRAV, 5'd3, 6'd2);
        wait_commit("grav2");

        // both keys together and a stray lock_ack: nothing issued
        key_left = 1'b1; key_right = 1'b1; lock_ack = 1'b1;
        @(negedge clk);
        key_left = 1'b0; key_right = 1'b0; lock_ack = 1'b0;
        en_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (chk_en) en_seen = 1'b1;
            @(negedge clk);
        end
        check_eq("both_keys_no_chk", en_seen, 0);
        check_eq("both_keys_grav_issue", dbg_state, S_ISSUE);
        check_eq("both_keys_grav_mode", {chk_left, chk_right}, 0);
        push_exp(CHK_GRAV, 5'd3, 6'd3);
        wait_commit("grav3");

        // right pressed on the gravity wrap cycle: gravity first, right second
        repeat (9) @(negedge clk);
        check_eq("pre_right_idle", chk_en, 0);
        key_right = 1'b1;
        push_exp(CHK_GRAV, 5'd3, 6'd4);
        push_exp(CHK_RIGHT, 5'd4, 6'd4);
        @(negedge clk); key_right = 1'b0;
        wait_commit("prio_grav");
        wait_commit("prio_right");

        // fall to y=12, then collide and lock
        ey = 4;
        while (ey < 12) begin
            ey++;
            push_exp(CHK_GRAV, 5'd4, 6'(ey));
            wait_commit("fall");
        end
        coll_force = 1'b1;
        next_block = 3'd5;
        push_exp(CHK_GRAV, 5'd4, 6'd12);
        wait_commit("lock_grav");
        check_eq("lock_state", dbg_state, S_LOCK);
        lock_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (lock_req) lock_cnt++;
            @(negedge clk);
        end
        if (lock_req) lock_cnt++;
        check_eq("lock_frozen_y", piece_y, 12);
        lock_ack = 1'b1;
        @(negedge clk); lock_ack = 1'b0;
        check_eq("lock_held_cycles", lock_cnt, 5);
        check_eq("lock_to_spawn", dbg_state, S_SPAWN);
        check_eq("lock_req_drop", lock_req, 0);
        @(negedge clk);
        check_eq("respawn_xy", {piece_x, piece_y}, {5'd4, 6'd0});
        check_eq("respawn_blk", piece_block, 5);

        // collision at spawn row -> game over
        push_exp(CHK_GRAV, 5'd4, 6'd0);
        wait_commit("over_grav");
        check_eq("over_state", dbg_state, S_OVER);
        check_eq("over_flag", game_over, 1);
        @(negedge clk);
        check_eq("over_hold", game_over, 1);

        // restart, then reset in the middle of CHECK
        coll_force = 1'b0;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        check_eq("restart_clears_over", game_over, 0);
        repeat (3) @(negedge clk);
        check_eq("mid_check_en", chk_en, 1);
        reset = 1'b1;
        #1;
        check_eq("rst_mid_chk_en", chk_en, 0);
        check_eq("rst_mid_state", dbg_state, S_IDLE);
        check_eq("rst_mid_piece", {piece_x, piece_y, piece_block, piece_rot}, 0);
        check_eq("rst_mid_outs", {chk_left, chk_right, lock_req, game_over}, 0);
        @(negedge clk); reset = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("post_rst_idle", dbg_state, S_IDLE);

        check_eq("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
